// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, default memory timeout
// and common field widths.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int          REG_W           = 3;
    localparam int          WAIT_W          = 8;
    localparam int          CNT_W           = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/complete handshake between the hazard controller and the memory.
interface pipe_hazard_ctrl_if;
    logic mem_req;
    logic mem_done;

    modport master (output mem_req, input mem_done);
    modport slave  (input mem_req, output mem_done);
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID-stage source that needs the result of a load in EX.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             memRead_EX,
    input  logic             regWrite_EX,
    input  logic [REG_W-1:0] writeReg_EX,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             rs_used_ID,
    input  logic             rt_used_ID,
    output logic             load_use
);

    logic [1:0]       src_used;
    logic [REG_W-1:0] src_reg [2];
    logic [1:0]       src_hit;

    assign src_used   = {rt_used_ID, rs_used_ID};
    assign src_reg[0] = Rs_ID;
    assign src_reg[1] = Rt_ID;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_reg[gi] == writeReg_EX);
        end
    endgenerate

    assign load_use = memRead_EX && regWrite_EX && (|src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait/timeout FSM,
// sticky halt and error flags, and a saturating stalled-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memRead_EX,
    input  logic                  regWrite_EX,
    input  logic [REG_W-1:0]      writeReg_EX,
    input  logic [REG_W-1:0]      Rs_ID,
    input  logic [REG_W-1:0]      Rt_ID,
    input  logic                  rs_used_ID,
    input  logic                  rt_used_ID,
    input  logic                  branch_taken_EX,
    input  logic                  memRead_MEM,
    input  logic                  memWrite_MEM,
    input  logic                  halt_MEM,
    pipe_hazard_ctrl_if.master    mem_if,
    output logic                  stall,
    output logic                  takeBranch,
    output logic                  mem_stall,
    output logic                  halted,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [WAIT_W:0] TIMEOUT_CMP = (WAIT_W+1)'(TIMEOUT);

    pipe_state_t       state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              halted_reg;
    logic              mem_err_reg;
    logic [CNT_W-1:0]  stall_count_reg;

    logic load_use;
    logic mem_access;
    logic wait_last;
    logic mem_req_int;
    logic mem_stall_int;
    logic take_branch_int;
    logic stall_int;

    hazard_detect u_hazard_detect (
        .memRead_EX  (memRead_EX),
        .regWrite_EX (regWrite_EX),
        .writeReg_EX (writeReg_EX),
        .Rs_ID       (Rs_ID),
        .Rt_ID       (Rt_ID),
        .rs_used_ID  (rs_used_ID),
        .rt_used_ID  (rt_used_ID),
        .load_use    (load_use)
    );

    assign mem_access = memRead_MEM | memWrite_MEM;
    // True on the MEM_WAIT cycle that brings the wait count up to TIMEOUT.
    assign wait_last  = ({1'b0, wait_cnt_reg} + 1'b1) == TIMEOUT_CMP;

    // Every control output is forced low while reset is held, even if the
    // MEM-stage inputs still show an access.
    always_comb begin
        mem_req_int     = rst && (((state_reg == RUN) && mem_access) || (state_reg == MEM_WAIT));
        mem_stall_int   = rst && ((mem_req_int && !mem_if.mem_done) || (state_reg == HALT));
        take_branch_int = rst && branch_taken_EX && !mem_stall_int;
        stall_int       = rst && load_use && !branch_taken_EX && !mem_stall_int;
    end

    assign mem_if.mem_req = mem_req_int;
    assign mem_stall      = mem_stall_int;
    assign takeBranch     = take_branch_int;
    assign stall          = stall_int;
    assign halted         = halted_reg;
    assign mem_err        = mem_err_reg;
    assign stall_count    = stall_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            halted_reg      <= 1'b0;
            mem_err_reg     <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            if ((stall_int || mem_stall_int) && (state_reg != HALT)) begin
                stall_count_reg <= sat_inc(stall_count_reg);
            end

            unique case (state_reg)
                RUN: begin
                    // A pending access wins over halt so the access completes first.
                    if (mem_access && !mem_if.mem_done) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= '0;
                    end else if (halt_MEM && !mem_stall_int) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_if.mem_done) begin
                        state_reg <= RUN;
                    end else if (wait_last) begin
                        state_reg   <= RUN;
                        mem_err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memRead_EX, regWrite_EX;
    logic [2:0]  writeReg_EX, Rs_ID, Rt_ID;
    logic        rs_used_ID, rt_used_ID;
    logic        branch_taken_EX;
    logic        memRead_MEM, memWrite_MEM, halt_MEM;
    logic        stall, takeBranch, mem_stall, halted, mem_err;
    logic [15:0] stall_count;

    pipe_hazard_ctrl_if mif ();

    pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .memRead_EX      (memRead_EX),
        .regWrite_EX     (regWrite_EX),
        .writeReg_EX     (writeReg_EX),
        .Rs_ID           (Rs_ID),
        .Rt_ID           (Rt_ID),
        .rs_used_ID      (rs_used_ID),
        .rt_used_ID      (rt_used_ID),
        .branch_taken_EX (branch_taken_EX),
        .memRead_MEM     (memRead_MEM),
        .memWrite_MEM    (memWrite_MEM),
        .halt_MEM        (halt_MEM),
        .mem_if          (mif),
        .stall           (stall),
        .takeBranch      (takeBranch),
        .mem_stall       (mem_stall),
        .halted          (halted),
        .mem_err         (mem_err),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: an access is either absent, being attempted this cycle,
    // or outstanding for m_waited cycles after its first cycle.
    bit m_outstanding;
    int m_waited;
    bit m_halt;
    bit m_err;
    int m_cnt;

    bit obs_req, obs_ms;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        memRead_EX = 0; regWrite_EX = 0; writeReg_EX = 0; Rs_ID = 0; Rt_ID = 0;
        rs_used_ID = 0; rt_used_ID = 0; branch_taken_EX = 0;
        memRead_MEM = 0; memWrite_MEM = 0; halt_MEM = 0; mif.mem_done = 0;
    endtask

    task automatic apply_reset();
        rst = 0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_takeBranch", takeBranch, 0);
        check("rst_mem_stall", mem_stall, 0);
        check("rst_mem_req", mif.mem_req, 0);
        check("rst_halted", halted, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_stall_count", stall_count, 0);
        m_outstanding = 0; m_waited = 0; m_halt = 0; m_err = 0; m_cnt = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
    endtask

    // One clock: inputs are already driven; check combinational outputs, advance model, check state.
    task automatic cycle();
        bit acc, lu, e_req, e_ms, e_tb, e_st;
        #1;
        acc   = memRead_MEM || memWrite_MEM;
        lu    = memRead_EX && regWrite_EX &&
                ((rs_used_ID && (Rs_ID == writeReg_EX)) || (rt_used_ID && (Rt_ID == writeReg_EX)));
        e_req = !m_halt && (m_outstanding || acc);
        e_ms  = m_halt || (e_req && !mif.mem_done);
        e_tb  = branch_taken_EX && !e_ms;
        e_st  = lu && !branch_taken_EX && !e_ms;
        obs_req = mif.mem_req;
        obs_ms  = mem_stall;
        check("mem_req", mif.mem_req, e_req);
        check("mem_stall", mem_stall, e_ms);
        check("takeBranch", takeBranch, e_tb);
        check("stall", stall, e_st);

        if (!m_halt && (e_st || e_ms) && m_cnt < 65535) m_cnt++;
        if (!m_halt) begin
            if (m_outstanding) begin
                if (mif.mem_done) m_outstanding = 0;
                else if (m_waited + 1 == TO) begin m_outstanding = 0; m_err = 1; end
                else m_waited++;
            end else if (acc && !mif.mem_done) begin
                m_outstanding = 1; m_waited = 0;
            end else if (halt_MEM) begin
                m_halt = 1;
            end
        end

        @(posedge clk); #1;
        check("halted", halted, m_halt);
        check("mem_err", mem_err, m_err);
        check("stall_count", stall_count, m_cnt);
    endtask

    task automatic set_hazard();
        memRead_EX = 1; regWrite_EX = 1; writeReg_EX = 3'd3; Rs_ID = 3'd3; rs_used_ID = 1;
        Rt_ID = 3'd5; rt_used_ID = 1;
    endtask

    initial begin
        int n_req, n_ms;
        clear_inputs();
        apply_reset();

        // Load-use hazard stalls exactly one cycle; the bubble then clears memRead_EX.
        set_hazard();
        cycle();
        check("lu_stall_fixed", obs_ms, 0);
        check("lu_stall_seen", stall_count, 1);
        memRead_EX = 0;
        cycle();
        check("lu_bubble_count", stall_count, 1);

        // Hazard with a taken branch: flush wins over stall.
        set_hazard();
        branch_taken_EX = 1;
        cycle();
        check("br_no_stall_count", stall_count, 1);
        clear_inputs();
        cycle();

        // Read that completes after four stalled cycles; branch is suppressed while stalled.
        apply_reset();
        memRead_MEM = 1; branch_taken_EX = 1;
        n_req = 0; n_ms = 0;
        for (int i = 0; i < 5; i++) begin
            mif.mem_done = (i == 4);
            cycle();
            n_req += int'(obs_req);
            n_ms  += int'(obs_ms);
        end
        check("rd_req_cycles", n_req, 5);
        check("rd_stall_cycles", n_ms, 4);
        check("rd_stall_count", stall_count, 4);
        clear_inputs();
        cycle();

        // Zero-wait write: done in the same cycle, no stall at all.
        memWrite_MEM = 1; mif.mem_done = 1;
        cycle();
        check("zw_no_stall", obs_ms, 0);
        clear_inputs();

        // Write that never completes: error after 255 wait cycles, back in RUN.
        apply_reset();
        memWrite_MEM = 1;
        for (int i = 0; i < 255; i++) cycle();
        check("to_err_early", mem_err, 0);
        cycle();
        check("to_err_set", mem_err, 1);
        memWrite_MEM = 0;
        cycle();
        check("to_run_no_req", obs_req, 0);
        check("to_err_sticky", mem_err, 1);

        // Halt together with a pending read: the read finishes first.
        apply_reset();
        memRead_MEM = 1; halt_MEM = 1;
        cycle();
        check("halt_wait_access", halted, 0);
        mif.mem_done = 1;
        cycle();
        check("halt_after_access", halted, 0);
        memRead_MEM = 0; mif.mem_done = 0;
        cycle();
        check("halt_entered", halted, 1);
        clear_inputs();
        set_hazard(); branch_taken_EX = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("halt_mem_stall", obs_ms, 1);
        end
        clear_inputs();
        apply_reset();
        cycle();
        check("post_halt_run", obs_ms, 0);

        // Reset in the middle of a memory wait abandons the access.
        memRead_MEM = 1;
        for (int i = 0; i < 3; i++) cycle();
        apply_reset();
        memRead_MEM = 0;
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            memRead_EX      = ($urandom_range(0, 1) == 1);
            regWrite_EX     = ($urandom_range(0, 3) != 0);
            writeReg_EX     = 3'($urandom_range(0, 7));
            Rs_ID           = ($urandom_range(0, 1) == 1) ? writeReg_EX : 3'($urandom_range(0, 7));
            Rt_ID           = ($urandom_range(0, 1) == 1) ? writeReg_EX : 3'($urandom_range(0, 7));
            rs_used_ID      = ($urandom_range(0, 1) == 1);
            rt_used_ID      = ($urandom_range(0, 1) == 1);
            branch_taken_EX = ($urandom_range(0, 4) == 0);
            memRead_MEM     = ($urandom_range(0, 3) == 0);
            memWrite_MEM    = ($urandom_range(0, 5) == 0);
            halt_MEM        = ($urandom_range(0, 59) == 0);
            mif.mem_done    = ($urandom_range(0, 2) == 0);
            cycle();
            if (m_halt && $urandom_range(0, 3) == 0) apply_reset();
        end
        clear_inputs();

        // Saturation of the stalled-cycle counter under a hazard held for 65540 cycles.
        apply_reset();
        set_hazard();
        for (int i = 0; i < 65540; i++) cycle();
        check("sat_count", stall_count, 16'hFFFF);
        clear_inputs();
        cycle();
        check("sat_hold", stall_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max mem wait cycles before error.
REQ-002 SHALL have port clk  in  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports memRead_EX, regWrite_EX  in  1 each  control bits of the instruction in EX.
REQ-005 SHALL have port writeReg_EX  in  3  destination register of the instruction in EX.
REQ-006 SHALL have ports Rs_ID, Rt_ID  in  3 each  source registers of the instruction in ID.
REQ-007 SHALL have ports rs_used_ID, rt_used_ID  in  1 each  ID instruction reads Rs/Rt.
REQ-008 SHALL have port branch_taken_EX  in  1  EX resolved a taken branch or jump.
REQ-009 SHALL have ports memRead_MEM, memWrite_MEM, halt_MEM  in  1 each  MEM-stage controls.
REQ-010 SHALL have port mem_done  in  1  data memory completed the current access.
REQ-011 SHALL have port stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-012 SHALL have port takeBranch  out  1  flush IF/ID and ID/EX.
REQ-013 SHALL have port mem_stall  out  1  freeze every pipeline register.
REQ-014 SHALL have port mem_req  out  1  level request to data memory.
REQ-015 SHALL have ports halted, mem_err  out  1 each  sticky halt / timeout flags.
REQ-016 SHALL have port stall_count  out  16  saturating count of stalled cycles.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, HALT; reset state RUN.
REQ-018 RUN: mem_access = memRead_MEM|memWrite_MEM; if mem_access & ~mem_done -> MEM_WAIT; if halt_MEM & ~mem_stall -> HALT; else stay.
REQ-019 MEM_WAIT: mem_done -> RUN; wait counter reaching TIMEOUT -> RUN with mem_err set sticky.
REQ-020 HALT: terminal; leave only via rst.
REQ-021 mem_req SHALL be 1 when (RUN & mem_access) or MEM_WAIT, combinational, held until mem_done.
REQ-022 mem_stall SHALL be 1 when mem_req & ~mem_done, or state HALT; zero-wait access (mem_done same cycle) SHALL cause no stall.
REQ-023 load_use = memRead_EX & regWrite_EX & ((rs_used_ID & Rs_ID==writeReg_EX) | (rt_used_ID & Rt_ID==writeReg_EX)).
REQ-024 Priority mem_stall > takeBranch > stall: takeBranch = branch_taken_EX & ~mem_stall; stall = load_use & ~branch_taken_EX & ~mem_stall.
REQ-025 load_use stall SHALL last exactly one cycle per hazard (bubble clears memRead_EX).
REQ-026 Wait counter: 8-bit, cleared on entry to MEM_WAIT, +1 per MEM_WAIT cycle.
REQ-027 stall_count SHALL +1 each cycle stall|mem_stall is 1 outside HALT; saturate at 16'hFFFF.
REQ-028 halt_MEM with simultaneous pending access SHALL complete the access before entering HALT.

Reset
REQ-029 rst low SHALL immediately force RUN, wait counter 0, halted 0, mem_err 0, stall_count 0.
REQ-030 During reset stall, takeBranch, mem_stall, mem_req SHALL read 0; reset mid-MEM_WAIT abandons the access.

Structure
REQ-031 State encoding and TIMEOUT default SHALL live in a shared pipeline package.
REQ-032 Load-use comparator SHALL be sub-module hazard_detect (purely combinational); FSM and counters in top.

Verification
REQ-033 memRead_EX=1, regWrite_EX=1, writeReg_EX=3, Rs_ID=3, rs_used_ID=1 -> stall=1 one cycle, takeBranch=0.
REQ-034 Same hazard plus branch_taken_EX=1 -> takeBranch=1, stall=0.
REQ-035 memRead_MEM=1, mem_done after 4 cycles -> mem_req high 5 cycles, mem_stall high 4, stall_count=4, branch_taken_EX=1 meanwhile gives takeBranch=0.
REQ-036 memWrite_MEM=1, mem_done never -> after 255 wait cycles mem_err=1, FSM RUN.
REQ-037 halt_MEM=1 -> next cycle halted=1, mem_stall=1 permanently; rst low then high -> all outputs 0, RUN.
REQ-038 stall_count preloaded by 65540 stalled cycles -> holds 16'hFFFF.
